// File: rtl/ripple_carry_adder_pkg.sv
// ripple_carry_adder_pkg
//   Shared constants for the ripple-carry adder slice.
//   RCA_DEFAULT_WIDTH : default operand/result width used by the interface
//                       and the adder top when no override is given.
package ripple_carry_adder_pkg;

  localparam int RCA_DEFAULT_WIDTH = 8;

endpackage : ripple_carry_adder_pkg

// File: rtl/ripple_carry_adder_if.sv
// ripple_carry_adder_if
//   Operand/result bundle for the ripple-carry adder.
//   Signals:
//     valid_in  operands valid this cycle       (master -> slave)
//     A, B      N-bit operands                  (master -> slave)
//     cin       carry into bit 0                (master -> slave)
//     Sum       registered N-bit result         (slave -> master)
//     cout      registered unsigned carry out   (slave -> master)
//     overflow  registered signed overflow      (slave -> master)
//     zero      registered Sum == 0 flag        (slave -> master)
//     valid_out registered copy of valid_in     (slave -> master)
//   Modports: master drives operands, slave (the adder) drives results.
interface ripple_carry_adder_if
  import ripple_carry_adder_pkg::*;
#(
  parameter int N = RCA_DEFAULT_WIDTH
);

  logic         valid_in;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         cin;
  logic [N-1:0] Sum;
  logic         cout;
  logic         overflow;
  logic         zero;
  logic         valid_out;

  modport master (
    output valid_in, A, B, cin,
    input  Sum, cout, overflow, zero, valid_out
  );

  modport slave (
    input  valid_in, A, B, cin,
    output Sum, cout, overflow, zero, valid_out
  );

endinterface : ripple_carry_adder_if

// File: rtl/ripple_carry_adder_full_adder.sv
// full_adder
//   One-bit combinational full adder, the cell of the ripple chain.
//   Ports:
//     a, b  operand bits
//     ci    carry in
//     s     sum bit   = a ^ b ^ ci
//     co    carry out = generate | (carry-in & propagate)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder
//   N-bit ripple-carry adder (Sum = A + B + cin) built from a chain of
//   full_adder cells, followed by a single output register stage. Fixed
//   1-cycle latency; a new operand set may be presented every cycle.
//   Ports:
//     clk  clock, all state updates on the rising edge
//     rst  synchronous active-high reset, clears every registered output
//     bus  ripple_carry_adder_if.slave carrying operands in and registered
//          Sum / cout / overflow / zero / valid_out back
module ripple_carry_adder
  import ripple_carry_adder_pkg::*;
#(
  parameter int N = RCA_DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  ripple_carry_adder_if.slave    bus
);

  // c[i] is the carry into bit i; c[N] is the carry out of the MSB.
  logic [N:0]   c;
  logic [N-1:0] s;

  logic [N-1:0] sum_reg;
  logic         cout_reg;
  logic         overflow_reg;
  logic         zero_reg;
  logic         valid_reg;

  logic         overflow_next;
  logic         zero_next;

  assign c[0] = bus.cin;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_fa
      full_adder u_fa (
        .a  (bus.A[gi]),
        .b  (bus.B[gi]),
        .ci (c[gi]),
        .s  (s[gi]),
        .co (c[gi+1])
      );
    end
  endgenerate

  // Carry into the sign bit disagreeing with carry out of it is exactly the
  // "same-sign operands, different-sign result" case. For N = 1 this reduces
  // to cin ^ cout.
  assign overflow_next = c[N-1] ^ c[N];
  assign zero_next     = (s == '0);

  // Datapath registers load every cycle; valid_in only qualifies valid_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg      <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      sum_reg      <= s;
      cout_reg     <= c[N];
      overflow_reg <= overflow_next;
      zero_reg     <= zero_next;
      valid_reg    <= bus.valid_in;
    end
  end

  assign bus.Sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.zero      = zero_reg;
  assign bus.valid_out = valid_reg;

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder
//   Directed-vector bench for the 8-bit ripple-carry adder. Operands are
//   driven on the falling edge, captured on the rising edge, and results
//   sampled 1 time unit after that edge (1-cycle latency).
module tb_ripple_carry_adder;
  import ripple_carry_adder_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;

  int n_vec;
  int n_bad;

  ripple_carry_adder_if #(.N(W)) bus ();

  ripple_carry_adder #(.N(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one operand set, let it be captured, then report the registered result.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic v, input logic r);
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.cin      = ci;
    bus.valid_in = v;
    rst          = r;
    @(posedge clk);
    #1;
    $display("txn rst=%b A=%h B=%h cin=%b v=%b -> Sum=%h cout=%b ovf=%b zero=%b vout=%b",
             r, a, b, ci, v, bus.Sum, bus.cout, bus.overflow, bus.zero, bus.valid_out);
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] sum, input logic co,
                         input logic ov, input logic z, input logic vo);
    chk({tag, ".sum"},  32'(bus.Sum),       32'(sum));
    chk({tag, ".cout"}, 32'(bus.cout),      32'(co));
    chk({tag, ".ovf"},  32'(bus.overflow),  32'(ov));
    chk({tag, ".zero"}, 32'(bus.zero),      32'(z));
    chk({tag, ".vout"}, 32'(bus.valid_out), 32'(vo));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rv;
    logic [W:0]   full;
    logic         exp_ov;

    n_vec = 0;
    n_bad = 0;
    rst          = 1'b1;
    bus.A        = '0;
    bus.B        = '0;
    bus.cin      = 1'b0;
    bus.valid_in = 1'b0;

    // 1. reset held two cycles with live operands
    apply(8'hAA, 8'h55, 1'b1, 1'b1, 1'b1);
    chk_all("rst0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(8'hAA, 8'h55, 1'b1, 1'b1, 1'b1);
    chk_all("rst1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2. all-zero operands
    apply(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    chk_all("zero", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // 3. full-length ripple: FF + 00 + 1
    apply(8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
    chk_all("ripple", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);

    // wrap-around: FF + 01 + 0, valid_in low
    apply(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    chk_all("wrap", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

    // 4. signed overflow, positive and negative
    apply(8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
    chk_all("ovpos", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    apply(8'h80, 8'h80, 1'b0, 1'b1, 1'b0);
    chk_all("ovneg", 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);

    // 5. back-to-back, then reset mid-stream
    apply(8'd100, 8'd55, 1'b1, 1'b1, 1'b0);
    chk_all("b2b0", 8'd156, 1'b0, 1'b1, 1'b0, 1'b1);
    apply(8'd200, 8'd100, 1'b0, 1'b1, 1'b0);
    chk_all("b2b1", 8'd44, 1'b1, 1'b0, 1'b0, 1'b1);
    apply(8'd200, 8'd100, 1'b0, 1'b1, 1'b1);
    chk_all("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6. random vectors against a behavioural A+B+cin model
    for (int i = 0; i < 100; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      full   = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      exp_ov = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
      apply(ra, rb, rc, rv, 1'b0);
      chk_all($sformatf("rnd%0d", i), full[W-1:0], full[W], exp_ov,
              (full[W-1:0] == '0), rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_ripple_carry_adder
